// File: rtl/rbm_frame_sequencer.sv
// rtl/rbm_frame_sequencer.sv - host-side image loader and vote argmax for the RBM controller
module rbm_frame_sequencer #(
    parameter int general_input_dim = 784,
    parameter int output_dim        = 10,
    parameter int bitlength         = 12,
    parameter int beat_width        = 16,
    parameter int label_width       = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [beat_width-1:0]             s_data,
    output logic                              core_reset,
    output logic                              data_valid,
    output logic [general_input_dim-1:0]      InputData,
    input  logic [output_dim*bitlength-1:0]   OutputData,
    input  logic                              finish,
    output logic                              label_valid,
    input  logic                              label_ready,
    output logic [label_width-1:0]            label,
    output logic [bitlength-1:0]              max_count
);
    localparam int nb = (general_input_dim + beat_width - 1) / beat_width;
    localparam int cw = (nb > 1) ? $clog2(nb) : 1;

    typedef enum logic [2:0] {LOAD, RELEASE, RUN, SCAN, EMIT} state_t;

    state_t                 state, state_next;
    logic [cw-1:0]          beat_cnt;
    logic                   run_armed;
    logic [label_width-1:0] scan_idx, best_idx, take_idx;
    logic [bitlength-1:0]   best, cur, take_val;
    logic                   take, beat_acc, last_beat, last_scan;

    assign beat_acc  = s_valid && (state == LOAD);
    assign last_beat = (beat_cnt == cw'(nb - 1));
    assign last_scan = (scan_idx == label_width'(output_dim - 1));
    assign cur       = OutputData[int'(scan_idx)*bitlength +: bitlength];

    // Index 0 seeds the running maximum; strict compare keeps the lowest index on ties.
    assign take      = (scan_idx == '0) || (cur > best);
    assign take_val  = take ? cur : best;
    assign take_idx  = take ? scan_idx : best_idx;

    always_comb begin
        state_next  = state;
        s_ready     = 1'b0;
        core_reset  = 1'b0;
        data_valid  = 1'b0;
        label_valid = 1'b0;
        case (state)
            LOAD: begin
                s_ready    = 1'b1;
                core_reset = 1'b1;
                if (beat_acc && last_beat) state_next = RELEASE;
            end
            RELEASE: state_next = RUN;
            RUN: begin
                data_valid = 1'b1;
                // run_armed masks a finish left over from the previous image.
                if (run_armed && finish) state_next = SCAN;
            end
            SCAN: begin
                data_valid = 1'b1;
                if (last_scan) state_next = EMIT;
            end
            EMIT: begin
                label_valid = 1'b1;
                core_reset  = 1'b1;
                if (label_ready) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LOAD;
            beat_cnt  <= '0;
            InputData <= '0;
            run_armed <= 1'b0;
            scan_idx  <= '0;
            best      <= '0;
            best_idx  <= '0;
            label     <= '0;
            max_count <= '0;
        end else begin
            state     <= state_next;
            run_armed <= (state == RUN);
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                // Bits past general_input_dim in the final beat have no destination.
                for (int j = 0; j < general_input_dim; j++) begin
                    if (j / beat_width == int'(beat_cnt)) InputData[j] <= s_data[j % beat_width];
                end
            end
            if (state == SCAN) begin
                best     <= take_val;
                best_idx <= take_idx;
                scan_idx <= last_scan ? '0 : scan_idx + 1'b1;
                if (last_scan) begin
                    label     <= take_idx;
                    max_count <= take_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_rbm_frame_sequencer.sv
// tb/tb_rbm_frame_sequencer.sv - randomized self-checking bench for rbm_frame_sequencer
module tb_rbm_frame_sequencer;
    localparam int GID = 784;
    localparam int OD  = 10;
    localparam int BL  = 12;
    localparam int BW  = 16;
    localparam int LW  = 4;
    localparam int NB  = (GID + BW - 1) / BW;

    logic              clock = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [BW-1:0]     s_data;
    logic              core_reset;
    logic              data_valid;
    logic [GID-1:0]    InputData;
    logic [OD*BL-1:0]  OutputData;
    logic              finish;
    logic              label_valid;
    logic              label_ready;
    logic [LW-1:0]     label;
    logic [BL-1:0]     max_count;

    logic [BW-1:0] beat_mem [NB];
    logic [BL-1:0] counts   [OD];
    int n_cmp = 0;
    int n_err = 0;

    rbm_frame_sequencer #(
        .general_input_dim(GID), .output_dim(OD), .bitlength(BL),
        .beat_width(BW), .label_width(LW)
    ) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .core_reset(core_reset), .data_valid(data_valid),
        .InputData(InputData), .OutputData(OutputData), .finish(finish),
        .label_valid(label_valid), .label_ready(label_ready),
        .label(label), .max_count(max_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [GID-1:0] obs, input logic [GID-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Streams the first n beats of beat_mem; inputs change and handshakes are judged at negedges.
    task automatic send_frame(input bit gaps, input int n);
        int  k = 0;
        int  guard = 0;
        bit  acc;
        while (k < n && guard < 2000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = beat_mem[k];
            acc     = s_valid && s_ready;
            @(negedge clock);
            if (acc) k++;
            guard++;
        end
        s_valid = 1'b0;
        if (guard >= 2000) check("beat_timeout", 1, 0);
    endtask

    task automatic run_frame(input bit gaps, input bit stale, input int hold, input bit rst_scan);
        logic [GID-1:0] exp_img, tmp;
        int best, bidx, lat;
        bit sready_bad;
        exp_img = '0;
        for (int k = 0; k < NB; k++) begin
            tmp = '0;
            tmp[BW-1:0] = beat_mem[k];
            exp_img = exp_img | (tmp << (k * BW));
        end
        best = 0;
        for (int i = 0; i < OD; i++) begin
            OutputData[i*BL +: BL] = counts[i];
            if (int'(counts[i]) > best) best = int'(counts[i]);
        end
        bidx = -1;
        for (int i = OD - 1; i >= 0; i--) if (int'(counts[i]) == best) bidx = i;

        send_frame(gaps, NB);
        check("release_core_reset", core_reset, 0);
        check("release_data_valid", data_valid, 0);
        check("release_s_ready", s_ready, 0);
        if (stale) finish = 1'b1;
        @(negedge clock);
        check("run_data_valid", data_valid, 1);
        check("run_image", InputData, exp_img);
        if (stale) begin
            @(negedge clock);
            finish = 1'b0;
            repeat (20) @(negedge clock);
            check("no_early_scan", label_valid, 0);
            check("still_running", data_valid, 1);
        end else begin
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end
        finish = 1'b1;
        if (rst_scan) begin
            repeat (5) @(negedge clock);
            pulse_reset();
            finish = 1'b0;
            check("scanrst_label_valid", label_valid, 0);
            check("scanrst_core_reset", core_reset, 1);
            check("scanrst_data_valid", data_valid, 0);
            check("scanrst_s_ready", s_ready, 1);
            repeat (15) @(negedge clock);
            check("scanrst_label_dropped", label_valid, 0);
            return;
        end
        lat = 0;
        sready_bad = 1'b0;
        while (!label_valid && lat < 200) begin
            @(negedge clock);
            lat++;
            if (s_ready) sready_bad = 1'b1;
        end
        finish = 1'b0;
        check("finish_to_label", lat, OD + 1);
        check("s_ready_low_busy", sready_bad, 0);
        check("label", label, bidx);
        check("max_count", max_count, best);
        check("emit_core_reset", core_reset, 1);
        check("emit_data_valid", data_valid, 0);
        s_valid = 1'b1;
        s_data  = 16'($urandom);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_label_valid", label_valid, 1);
            check("hold_label", label, bidx);
            check("hold_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        label_ready = 1'b1;
        @(negedge clock);
        label_ready = 1'b0;
        check("ack_label_valid", label_valid, 0);
        check("ack_s_ready", s_ready, 1);
        check("ack_label_kept", label, bidx);
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        OutputData = '0;
        finish = 1'b0;
        label_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_s_ready", s_ready, 1);
        check("rst_core_reset", core_reset, 1);
        check("rst_data_valid", data_valid, 0);
        check("rst_label_valid", label_valid, 0);
        check("rst_label", label, 0);
        check("rst_max_count", max_count, 0);
        check("rst_image", InputData, 0);
        reset = 1'b0;

        // All-ones image, tie among the 9s resolves to class 3.
        for (int k = 0; k < NB; k++) beat_mem[k] = 16'hFFFF;
        counts = '{12'd3, 12'd7, 12'd2, 12'd9, 12'd9, 12'd0, 12'd1, 12'd9, 12'd4, 12'd5};
        run_frame(1'b0, 1'b0, 5, 1'b0);

        // Beat k carries k, gapped stream, stale finish in first RUN cycle, all-zero votes.
        for (int k = 0; k < NB; k++) beat_mem[k] = 16'(k);
        for (int i = 0; i < OD; i++) counts[i] = '0;
        run_frame(1'b1, 1'b1, 2, 1'b0);

        // Saturated top class.
        for (int k = 0; k < NB; k++) beat_mem[k] = 16'($urandom);
        for (int i = 0; i < OD; i++) counts[i] = 12'd100;
        counts[OD-1] = 12'hFFF;
        run_frame(1'b1, 1'b0, 0, 1'b0);

        // Reset abandons a half-loaded frame.
        for (int k = 0; k < NB; k++) beat_mem[k] = 16'($urandom);
        send_frame(1'b1, 20);
        pulse_reset();
        check("midrst_label_valid", label_valid, 0);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_image", InputData, 0);
        for (int k = 0; k < NB; k++) beat_mem[k] = 16'($urandom);
        for (int i = 0; i < OD; i++) counts[i] = 12'($urandom);
        run_frame(1'b1, 1'b0, 1, 1'b0);

        // Reset during SCAN drops the pending label.
        run_frame(1'b0, 1'b0, 0, 1'b1);

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NB; k++) beat_mem[k] = 16'($urandom);
            for (int i = 0; i < OD; i++) counts[i] = 12'($urandom_range(0, 15));
            run_frame(1'b1, f[0], $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rbm_frame_sequencer.md
Name: rbm_frame_sequencer

Overview:
- Host-side counterpart of the RBM top-level controller.
- Deserialises an input image from a narrow valid/ready stream into the `general_input_dim`-bit binary vector and drives the controller's `reset`, `data_valid` and `InputData` inputs.
- Waits for the controller's `finish`, then argmaxes the per-class vote counts in `OutputData` and emits one class label per image over a valid/ready handshake.

Parameters:
- `general_input_dim`, 784: input vector width in bits.
- `output_dim`, 10: number of classes / vote counters.
- `bitlength`, 12: width of each vote counter.
- `beat_width`, 16: stream beat width in bits.
- `label_width`, 4: label width; must satisfy 2^`label_width` >= `output_dim`.

Ports:
- `clock`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high reset.
- `s_valid`, input, 1: stream beat valid.
- `s_ready`, output, 1: stream beat accepted when `s_valid` && `s_ready`.
- `s_data`, input, `beat_width`: pixel bits, LSB = lowest pixel index.
- `core_reset`, output, 1: drives the controller's `reset`.
- `data_valid`, output, 1: drives the controller's `data_valid`.
- `InputData`, output, `general_input_dim`: assembled image.
- `OutputData`, input, `output_dim`*`bitlength`: vote counts; class i occupies bits [i*`bitlength` +: `bitlength`].
- `finish`, input, 1: controller done.
- `label_valid`, output, 1: label available.
- `label_ready`, input, 1: label consumed when `label_valid` && `label_ready`.
- `label`, output, `label_width`: winning class index.
- `max_count`, output, `bitlength`: vote count of the winning class.

Behaviour:
- Reset values (synchronous, applied on a `clock` edge with `reset`=1):
  - state = LOAD, beat counter = 0, `InputData` = 0.
  - `s_ready` = 1, `core_reset` = 1, `data_valid` = 0.
  - `label_valid` = 0, `label` = 0, `max_count` = 0.
- Beats per frame: NB = ceil(`general_input_dim`/`beat_width`); 49 with defaults. Beat k writes `InputData` bits [k*`beat_width` +: `beat_width`]. Bits of the final beat beyond `general_input_dim` are discarded.
- LOAD state:
  - Outputs: `s_ready`=1, `core_reset`=1 (controller held in reset), `data_valid`=0.
  - Each accepted beat writes its slice and increments the beat counter.
  - On acceptance of beat NB-1: counter returns to 0 and state goes to RELEASE.
  - No beat is lost or duplicated under arbitrary `s_valid` gaps.
- RELEASE state (exactly 1 cycle):
  - Outputs: `core_reset`=0, `data_valid`=0, `s_ready`=0.
  - Next state: RUN.
- RUN state:
  - Outputs: `data_valid`=1, `core_reset`=0, `s_ready`=0; `InputData` is held stable.
  - `finish` is ignored in the first RUN cycle, guarding against a stale `finish`.
  - From the second RUN cycle on, `finish`=1 moves the state to SCAN. There is no timeout.
- SCAN state (`output_dim` cycles):
  - Outputs: `data_valid` stays 1, so the controller stays settled with `finish` high.
  - Index i steps 0..`output_dim`-1, one class per cycle.
  - At i=0: best = count[0], best_idx = 0.
  - At each i>0: if count[i] > best (unsigned, strictly greater), update best and best_idx. Ties resolve to the lowest index.
  - After i = `output_dim`-1: `label` = best_idx, `max_count` = best, `label_valid` = 1, state goes to EMIT.
- EMIT state:
  - Outputs: `label_valid`=1, `label`/`max_count` held stable; `data_valid`=0, `core_reset`=1.
  - On `label_ready`: `label_valid`=0 next cycle and state goes to LOAD (`s_ready`=1 next cycle). `label`/`max_count` keep their last values.
- Latency: from the last beat accepted to `data_valid` rising is 2 cycles. From `finish` sampled in RUN to `label_valid` rising is `output_dim`+1 cycles.
- `reset` asserted mid-frame, mid-RUN or mid-EMIT: all state is abandoned, outputs go to reset values on the next edge, and a pending label is dropped.
- Back-to-back frames: stream beats arriving during RELEASE/RUN/SCAN/EMIT are back-pressured (`s_ready`=0), never dropped.

Test Plan:
- Reset, then 49 beats with `s_data`=16'hFFFF, `s_valid` always 1 -> `InputData` = all 784 ones, `core_reset` falls 1 cycle after beat 48, `data_valid`=1 the cycle after.
- Beat k = k (16-bit) with random `s_valid` gaps -> `InputData`[k*16 +: 16] == k for k<49; `s_ready`=0 from acceptance of beat 48 until EMIT handshake.
- `finish`=1 already in the first RUN cycle, then dropped, then raised 20 cycles later -> no early SCAN; `label_valid` rises 11 cycles after the second `finish`.
- Counts {3,7,2,9,9,0,1,9,4,5} -> `label`=3, `max_count`=9 (tie resolved to lowest index); all zero -> `label`=0, `max_count`=0; count[9]=12'hFFF, others 100 -> `label`=9.
- `label_ready` held 0 for 5 cycles -> `label_valid`/`label` stable, no new beats accepted; `label_ready`=1 -> `label_valid`=0 and `s_ready`=1 next cycle, second frame processes correctly.
- `reset` pulsed at beat 20 and again during SCAN -> `label_valid`=0, `core_reset`=1, beat counter 0; a following full frame yields the correct label.
